// File: rtl/mux_32x1_reg_if.sv
// mux_32x1_reg_if: select, 32 data words and registered result of the word mux
interface mux_32x1_reg_if #(
   parameter int WIDTH = 32
);
   logic [4:0]       S;
   logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
   logic [WIDTH-1:0] I8, I9, I10, I11, I12, I13, I14, I15;
   logic [WIDTH-1:0] I16, I17, I18, I19, I20, I21, I22, I23;
   logic [WIDTH-1:0] I24, I25, I26, I27, I28, I29, I30, I31;
   logic [WIDTH-1:0] Y;
   modport master (
      output S,
      output I0, I1, I2, I3, I4, I5, I6, I7, I8, I9, I10, I11, I12, I13, I14, I15,
      output I16, I17, I18, I19, I20, I21, I22, I23, I24, I25, I26, I27, I28, I29, I30, I31,
      input  Y
   );
   modport slave (
      input  S,
      input  I0, I1, I2, I3, I4, I5, I6, I7, I8, I9, I10, I11, I12, I13, I14, I15,
      input  I16, I17, I18, I19, I20, I21, I22, I23, I24, I25, I26, I27, I28, I29, I30, I31,
      output Y
   );
endinterface

// File: rtl/mux_32x1_reg.sv
// mux_32x1_reg: registered 32-to-1 word multiplexer for register-file read-port selection
module mux_32x1_reg #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            reset,
   mux_32x1_reg_if.slave  bus
);
   logic [WIDTH-1:0] y_q, y_d;
   // pick the selected word; reset forces zero, an unknown select yields X in simulation
   always_comb begin
      y_d = '0;
      case (bus.S)
         5'd0:  y_d = bus.I0;
         5'd1:  y_d = bus.I1;
         5'd2:  y_d = bus.I2;
         5'd3:  y_d = bus.I3;
         5'd4:  y_d = bus.I4;
         5'd5:  y_d = bus.I5;
         5'd6:  y_d = bus.I6;
         5'd7:  y_d = bus.I7;
         5'd8:  y_d = bus.I8;
         5'd9:  y_d = bus.I9;
         5'd10: y_d = bus.I10;
         5'd11: y_d = bus.I11;
         5'd12: y_d = bus.I12;
         5'd13: y_d = bus.I13;
         5'd14: y_d = bus.I14;
         5'd15: y_d = bus.I15;
         5'd16: y_d = bus.I16;
         5'd17: y_d = bus.I17;
         5'd18: y_d = bus.I18;
         5'd19: y_d = bus.I19;
         5'd20: y_d = bus.I20;
         5'd21: y_d = bus.I21;
         5'd22: y_d = bus.I22;
         5'd23: y_d = bus.I23;
         5'd24: y_d = bus.I24;
         5'd25: y_d = bus.I25;
         5'd26: y_d = bus.I26;
         5'd27: y_d = bus.I27;
         5'd28: y_d = bus.I28;
         5'd29: y_d = bus.I29;
         5'd30: y_d = bus.I30;
         5'd31: y_d = bus.I31;
         default: y_d = 'x;
      endcase
      if (reset) y_d = '0;
   end
   // single output register; no combinational path from inputs to Y
   always_ff @(posedge clk) begin
      y_q <= y_d;
   end
   assign bus.Y = y_q;
endmodule

// File: tb/tb_mux_32x1_reg.sv
// tb_mux_32x1_reg: randomized and directed checks of the registered 32-to-1 mux
module tb_mux_32x1_reg;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  sel = '0;
   logic [31:0] din [32];
   logic [31:0] exp_y;
   int          checks = 0;
   int          failures = 0;

   mux_32x1_reg_if #(.WIDTH(32)) bus ();
   mux_32x1_reg #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   assign bus.S = sel;
   assign bus.I0  = din[0];  assign bus.I1  = din[1];  assign bus.I2  = din[2];  assign bus.I3  = din[3];
   assign bus.I4  = din[4];  assign bus.I5  = din[5];  assign bus.I6  = din[6];  assign bus.I7  = din[7];
   assign bus.I8  = din[8];  assign bus.I9  = din[9];  assign bus.I10 = din[10]; assign bus.I11 = din[11];
   assign bus.I12 = din[12]; assign bus.I13 = din[13]; assign bus.I14 = din[14]; assign bus.I15 = din[15];
   assign bus.I16 = din[16]; assign bus.I17 = din[17]; assign bus.I18 = din[18]; assign bus.I19 = din[19];
   assign bus.I20 = din[20]; assign bus.I21 = din[21]; assign bus.I22 = din[22]; assign bus.I23 = din[23];
   assign bus.I24 = din[24]; assign bus.I25 = din[25]; assign bus.I26 = din[26]; assign bus.I27 = din[27];
   assign bus.I28 = din[28]; assign bus.I29 = din[29]; assign bus.I30 = din[30]; assign bus.I31 = din[31];

   // reference: the word Y must hold after the next edge, from the inputs present before it
   function automatic logic [31:0] model_next();
      return reset ? 32'd0 : din[sel];
   endfunction

   task automatic tick();
      exp_y = model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 32; n++) din[n] = $urandom;
      din[0] = 32'h1234;
      sel = 5'd0;
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (bus.Y !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, bus.Y, 32'd0);
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.Y !== 32'h1234) begin
         failures++;
         $display("FAIL reset_release got=%h want=%h", bus.Y, 32'h1234);
      end
   endtask

   task automatic test_sweep();
      for (int n = 0; n < 32; n++) din[n] = n;
      for (int s = 0; s < 32; s++) begin
         sel = 5'(s);
         tick();
         checks++;
         if (bus.Y !== 32'(s)) begin
            failures++;
            $display("FAIL sweep s=%0d got=%h want=%h", s, bus.Y, 32'(s));
         end
      end
   endtask

   task automatic test_wrap();
      din[31] = 32'd31;
      din[0] = 32'd0;
      sel = 5'd31;
      tick();
      checks++;
      if (bus.Y !== 32'd31) begin
         failures++;
         $display("FAIL wrap_31 got=%h want=%h", bus.Y, 32'd31);
      end
      sel = 5'd0;
      tick();
      checks++;
      if (bus.Y !== 32'd0) begin
         failures++;
         $display("FAIL wrap_0 got=%h want=%h", bus.Y, 32'd0);
      end
   endtask

   task automatic test_signed();
      din[17] = 32'hFFFF_FFFB;
      sel = 5'd17;
      tick();
      checks++;
      if (bus.Y !== 32'hFFFF_FFFB) begin
         failures++;
         $display("FAIL signed_neg5 got=%h want=%h", bus.Y, 32'hFFFF_FFFB);
      end
      din[17] = 32'h8000_0000;
      tick();
      checks++;
      if (bus.Y !== 32'h8000_0000) begin
         failures++;
         $display("FAIL signed_min got=%h want=%h", bus.Y, 32'h8000_0000);
      end
   endtask

   task automatic test_isolation();
      din[9] = 32'h0909_0909;
      sel = 5'd9;
      tick();
      for (int c = 0; c < 4; c++) begin
         for (int n = 0; n < 32; n++) if (n != 9) din[n] = $urandom;
         tick();
         checks++;
         if (bus.Y !== 32'h0909_0909) begin
            failures++;
            $display("FAIL isolation cyc=%0d got=%h want=%h", c, bus.Y, 32'h0909_0909);
         end
      end
      din[9] = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (bus.Y !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL isolation_update got=%h want=%h", bus.Y, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 32; n++) din[n] = n;
      sel = 5'd19;
      tick();
      sel = 5'd20;
      reset = 1'b1;
      tick();
      checks++;
      if (bus.Y !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid got=%h want=%h", bus.Y, 32'd0);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.Y !== 32'd20) begin
         failures++;
         $display("FAIL reset_mid_release got=%h want=%h", bus.Y, 32'd20);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         sel = 5'($urandom_range(0, 31));
         for (int n = 0; n < 32; n++) din[n] = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            din[sel] = {1'b1, 31'($urandom)};
         end
         reset = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if (bus.Y !== exp_y) begin
            failures++;
            $display("FAIL random cyc=%0d s=%0d rst=%0b got=%h want=%h", c, sel, reset, bus.Y, exp_y);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] hist [$];
      for (int n = 0; n < 32; n++) din[n] = $urandom;
      for (int c = 0; c < 40; c++) begin
         sel = 5'($urandom_range(0, 31));
         din[sel] = $urandom;
         hist.push_back(din[sel]);
         @(posedge clk);
         #1;
         checks++;
         if (bus.Y !== hist[c]) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, bus.Y, hist[c]);
         end
      end
   endtask

   initial begin
      for (int n = 0; n < 32; n++) din[n] = '0;
      @(negedge clk);
      test_reset();
      test_sweep();
      test_wrap();
      test_signed();
      test_isolation();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
